intrpt_sequencer: RTL and testbench

// Machine-mode interrupt controller between interrupt sources and the CSR unit/pipeline.

---
 rtl/intrpt_sequencer_if.sv | 22 ++
 rtl/intrpt_sequencer.sv | 149 ++++++++++++++
 tb/tb_intrpt_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/intrpt_sequencer_if.sv
// Trap handshake and timer register bus between the interrupt sequencer and the CSR unit.
interface intrpt_sequencer_if;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic        trap_ack;
    logic        mret;
    logic        in_handler;
    logic        tmr_we;
    logic [1:0]  tmr_sel;
    logic [31:0] tmr_wdata;
    logic [31:0] tmr_rdata;

    modport master (
        output trap_req, trap_cause, in_handler, tmr_rdata,
        input  trap_ack, mret, tmr_we, tmr_sel, tmr_wdata
    );

    modport slave (
        input  trap_req, trap_cause, in_handler, tmr_rdata,
        output trap_ack, mret, tmr_we, tmr_sel, tmr_wdata
    );
endinterface

// File: rtl/intrpt_sequencer.sv
// Machine-mode interrupt sequencer: latches/arbitrates ext > timer, requests a trap at an
// instruction boundary and blocks nesting until MRET. INTRPT_SEQ_TIMER_EN adds mtime/mtimecmp.
module intrpt_sequencer #(
    parameter int          SYNC_STAGES = 2,
    parameter int          PRESCALE    = 1,
    parameter logic [31:0] CAUSE_EXT   = 32'h8000_000B,
    parameter logic [31:0] CAUSE_TMR   = 32'h8000_0007
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               irq_ext,
    input  logic               irq_tmr,
    input  logic               mstatus_mie,
    input  logic               mie_meie,
    input  logic               mie_mtie,
    input  logic               pipe_ready,
    output logic [1:0]         mip,
    intrpt_sequencer_if.master bus
);

    typedef enum logic [1:0] {IDLE, WAIT, REQ, HANDLER} state_t;

    state_t                 state, state_nxt;
    logic [31:0]            cause_q, cause_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ext_d;
    logic                   ext_rise;
    logic                   meip;
    logic                   mtip;
    logic                   ack_ext;
    logic                   ext_el, tmr_el, any_el;
    logic [31:0]            winner;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            ext_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_ext};
            ext_d  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign ext_rise = sync_q[SYNC_STAGES-1] & ~ext_d;
    assign ack_ext  = (state == REQ) & bus.trap_ack & (cause_q == CAUSE_EXT);

    // A new edge arriving in the same cycle as the acknowledge must not be lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) meip <= 1'b0;
        else       meip <= ext_rise | (meip & ~ack_ext);
    end

`ifdef INTRPT_SEQ_TIMER_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_q;
    logic [63:0]   mtime_q, mtimecmp_q, mtime_nxt;
    logic          tick;

    assign tick = (pre_q == PW'(PRESCALE - 1));

    // A software write to an mtime half overrides that half's increment.
    always_comb begin
        mtime_nxt = mtime_q + {63'd0, tick};
        if (bus.tmr_we && bus.tmr_sel == 2'd0) mtime_nxt[31:0]  = bus.tmr_wdata;
        if (bus.tmr_we && bus.tmr_sel == 2'd1) mtime_nxt[63:32] = bus.tmr_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q      <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
        end else begin
            pre_q   <= tick ? '0 : pre_q + PW'(1);
            mtime_q <= mtime_nxt;
            if (bus.tmr_we && bus.tmr_sel == 2'd2) mtimecmp_q[31:0]  <= bus.tmr_wdata;
            if (bus.tmr_we && bus.tmr_sel == 2'd3) mtimecmp_q[63:32] <= bus.tmr_wdata;
        end
    end

    assign mtip = (mtime_q >= mtimecmp_q);

    always_comb begin
        case (bus.tmr_sel)
            2'd0:    bus.tmr_rdata = mtime_q[31:0];
            2'd1:    bus.tmr_rdata = mtime_q[63:32];
            2'd2:    bus.tmr_rdata = mtimecmp_q[31:0];
            default: bus.tmr_rdata = mtimecmp_q[63:32];
        endcase
    end

    wire unused_irq_tmr = irq_tmr;
`else
    assign mtip          = irq_tmr;
    assign bus.tmr_rdata = '0;

    wire unused_tmr_bus = &{1'b0, bus.tmr_we, bus.tmr_sel, bus.tmr_wdata};
`endif

    assign ext_el = meip & mie_meie & mstatus_mie;
    assign tmr_el = mtip & mie_mtie & mstatus_mie;
    assign any_el = ext_el | tmr_el;
    assign winner = ext_el ? CAUSE_EXT : CAUSE_TMR;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cause_q <= '0;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cause_nxt = cause_q;
        case (state)
            IDLE: begin
                if (any_el) begin
                    state_nxt = WAIT;
                    cause_nxt = winner;
                end
            end
            WAIT: begin
                if (!any_el) begin
                    state_nxt = IDLE;
                end else begin
                    cause_nxt = winner;
                    if (pipe_ready) state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.trap_ack) state_nxt = HANDLER;
            end
            HANDLER: begin
                if (bus.mret) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.trap_req   = (state == REQ);
    assign bus.in_handler = (state == HANDLER);
    assign bus.trap_cause = cause_q;
    assign mip            = {meip, mtip};

endmodule

// File: tb/tb_intrpt_sequencer.sv
// Directed bench for intrpt_sequencer with a cycle-level behavioural model checked every cycle.
module tb_intrpt_sequencer;
    localparam int          S     = 2;
    localparam int          PRE   = 1;
    localparam logic [31:0] C_EXT = 32'h8000_000B;
    localparam logic [31:0] C_TMR = 32'h8000_0007;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       irq_ext = 1'b0, irq_tmr = 1'b0;
    logic       mstatus_mie = 1'b0, mie_meie = 1'b0, mie_mtie = 1'b0, pipe_ready = 1'b0;
    logic [1:0] mip;

    intrpt_sequencer_if bus();

    intrpt_sequencer dut (
        .clk(clk), .reset(reset), .irq_ext(irq_ext), .irq_tmr(irq_tmr),
        .mstatus_mie(mstatus_mie), .mie_meie(mie_meie), .mie_mtie(mie_mtie),
        .pipe_ready(pipe_ready), .mip(mip), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit run_cmp  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_req = 0, m_busy = 0, m_armed = 0, m_meip = 0;
    logic [31:0] m_cause = '0;
    bit          hq[$];
    logic [63:0] m_mtime = '0, m_cmp = '1, nt;
    int          m_pre = 0;
    bit          e_el, t_el, rise, tick;
    logic [31:0] win;

    function automatic bit m_mtip();
`ifdef INTRPT_SEQ_TIMER_EN
        return m_mtime >= m_cmp;
`else
        return irq_tmr;
`endif
    endfunction

    function automatic logic [31:0] m_rdata();
`ifdef INTRPT_SEQ_TIMER_EN
        case (bus.tmr_sel)
            2'd0:    return m_mtime[31:0];
            2'd1:    return m_mtime[63:32];
            2'd2:    return m_cmp[31:0];
            default: return m_cmp[63:32];
        endcase
`else
        return 32'h0;
`endif
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_req = 0; m_busy = 0; m_armed = 0; m_meip = 0; m_cause = '0;
            hq.delete();
            for (int i = 0; i <= S; i++) hq.push_back(1'b0);
            m_mtime = '0; m_cmp = '1; m_pre = 0;
        end else begin
            e_el = m_meip && mie_meie && mstatus_mie;
            t_el = m_mtip() && mie_mtie && mstatus_mie;
            win  = e_el ? C_EXT : C_TMR;
            // irq_ext as seen after S synchroniser flops, compared with one cycle earlier
            rise = hq[S-1] && !hq[S];
            hq.push_front(irq_ext);
            void'(hq.pop_back());
            if (m_req && bus.trap_ack && m_cause == C_EXT) m_meip = rise;
            else                                          m_meip = m_meip || rise;
            if (m_req) begin
                if (bus.trap_ack) begin m_req = 0; m_busy = 1; end
            end else if (m_busy) begin
                if (bus.mret) m_busy = 0;
            end else if (m_armed) begin
                if (!(e_el || t_el)) m_armed = 0;
                else begin
                    m_cause = win;
                    if (pipe_ready) begin m_armed = 0; m_req = 1; end
                end
            end else if (e_el || t_el) begin
                m_armed = 1;
                m_cause = win;
            end
`ifdef INTRPT_SEQ_TIMER_EN
            tick  = (m_pre == PRE - 1);
            m_pre = tick ? 0 : m_pre + 1;
            nt    = m_mtime + (tick ? 64'd1 : 64'd0);
            if (bus.tmr_we) begin
                case (bus.tmr_sel)
                    2'd0: nt[31:0]     = bus.tmr_wdata;
                    2'd1: nt[63:32]    = bus.tmr_wdata;
                    2'd2: m_cmp[31:0]  = bus.tmr_wdata;
                    2'd3: m_cmp[63:32] = bus.tmr_wdata;
                endcase
            end
            m_mtime = nt;
`endif
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("cyc_trap_req",   bus.trap_req,   m_req);
            chk("cyc_in_handler", bus.in_handler, m_busy);
            chk("cyc_trap_cause", bus.trap_cause, m_cause);
            chk("cyc_mip",        mip,            {m_meip, m_mtip()});
            chk("cyc_tmr_rdata",  bus.tmr_rdata,  m_rdata());
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ext();
        irq_ext = 1'b1;
        step();
        irq_ext = 1'b0;
    endtask

    task automatic wait_req(input int lim);
        int k = 0;
        while (!bus.trap_req && k < lim) begin
            step();
            k++;
        end
        chk("wait_trap_req", bus.trap_req, 1'b1);
    endtask

    task automatic ack_and_mret();
        bus.trap_ack = 1'b1;
        step();
        bus.trap_ack = 1'b0;
        step();
        bus.mret = 1'b1;
        step();
        bus.mret = 1'b0;
        step();
    endtask

    task automatic tmr_wr(input logic [1:0] sel, input logic [31:0] data);
        bus.tmr_we    = 1'b1;
        bus.tmr_sel   = sel;
        bus.tmr_wdata = data;
        step();
        bus.tmr_we    = 1'b0;
    endtask

    initial begin
        bus.trap_ack = 1'b0; bus.mret = 1'b0;
        bus.tmr_we = 1'b0; bus.tmr_sel = 2'd0; bus.tmr_wdata = '0;
        step();
        step();
        run_cmp = 1'b1;
        chk("rst_trap_req",   bus.trap_req,   1'b0);
        chk("rst_trap_cause", bus.trap_cause, 32'h0);
        chk("rst_in_handler", bus.in_handler, 1'b0);
        chk("rst_mip",        mip,            2'b00);
        reset = 1'b0;
        mstatus_mie = 1'b1; mie_meie = 1'b1; mie_mtie = 1'b1; pipe_ready = 1'b1;
        repeat (3) step();

        // external interrupt: latency from pulse, then ack and mret
        pulse_ext();
        repeat (3) step();
        chk("lat_before", bus.trap_req, 1'b0);
        step();
        chk("lat_req",    bus.trap_req,   1'b1);
        chk("lat_cause",  bus.trap_cause, C_EXT);
        chk("lat_mip",    mip,            2'b10);
        repeat (2) step();
        chk("req_hold", bus.trap_req, 1'b1);
        bus.trap_ack = 1'b1;
        step();
        bus.trap_ack = 1'b0;
        chk("ack_in_handler", bus.in_handler, 1'b1);
        chk("ack_meip_clr",   mip,            2'b00);
        repeat (2) step();
        bus.mret = 1'b1;
        step();
        bus.mret = 1'b0;
        chk("mret_in_handler", bus.in_handler, 1'b0);
        step();

        // ext and timer together: ext preempts during WAIT, timer follows after mret
        pipe_ready = 1'b0;
        irq_tmr = 1'b1;
        pulse_ext();
        repeat (6) step();
        chk("both_no_req",     bus.trap_req,   1'b0);
        chk("both_wait_cause", bus.trap_cause, C_EXT);
        pipe_ready = 1'b1;
        wait_req(10);
        chk("both_first", bus.trap_cause, C_EXT);
        bus.trap_ack = 1'b1;
        step();
        bus.trap_ack = 1'b0;
        bus.mret = 1'b1;
        step();
        bus.mret = 1'b0;
        wait_req(10);
        chk("both_second", bus.trap_cause, C_TMR);
        bus.trap_ack = 1'b1;
        step();
        bus.trap_ack = 1'b0;
        chk("tmr_ack_mtip_kept", mip, 2'b01);
        irq_tmr = 1'b0;
        bus.mret = 1'b1;
        step();
        bus.mret = 1'b0;
        repeat (2) step();

        // pipeline never ready, then enable withdrawn
        pipe_ready = 1'b0;
        pulse_ext();
        for (int i = 0; i < 7; i++) begin
            step();
            chk("stall_no_req", bus.trap_req, 1'b0);
        end
        mie_meie = 1'b0;
        repeat (2) step();
        pipe_ready = 1'b1;
        repeat (3) step();
        chk("withdrawn_no_req", bus.trap_req, 1'b0);
        chk("withdrawn_pend",   mip,          2'b10);
        mie_meie = 1'b1;
        wait_req(10);
        ack_and_mret();

        // strobes outside their states are ignored
        bus.trap_ack = 1'b1; bus.mret = 1'b1;
        step();
        bus.trap_ack = 1'b0; bus.mret = 1'b0;
        chk("stray_in_handler", bus.in_handler, 1'b0);
        chk("stray_trap_req",   bus.trap_req,   1'b0);

        // new ext edge lands on the same cycle as the ext acknowledge
        pulse_ext();
        wait_req(10);
        irq_ext = 1'b1;
        step();
        irq_ext = 1'b0;
        step();
        bus.trap_ack = 1'b1;
        step();
        bus.trap_ack = 1'b0;
        chk("setwin_in_handler", bus.in_handler, 1'b1);
        chk("setwin_meip",       mip[1],         1'b1);
        bus.mret = 1'b1;
        step();
        bus.mret = 1'b0;
        wait_req(10);
        ack_and_mret();

        // reset while requesting
        pulse_ext();
        wait_req(10);
        reset = 1'b1;
        step();
        chk("rstreq_trap_req",   bus.trap_req,   1'b0);
        chk("rstreq_in_handler", bus.in_handler, 1'b0);
        chk("rstreq_mip",        mip,            2'b00);
        chk("rstreq_cause",      bus.trap_cause, 32'h0);
        reset = 1'b0;
        step();

`ifdef INTRPT_SEQ_TIMER_EN
        mie_mtie = 1'b0;
        chk("tmr_rst_mtime", bus.tmr_rdata, 32'h0 + m_mtime[31:0]);
        tmr_wr(2'd3, 32'h0);
        tmr_wr(2'd2, 32'd10);
        tmr_wr(2'd1, 32'h0);
        tmr_wr(2'd0, 32'h0);
        chk("tmr_wr_lo", bus.tmr_rdata, 32'h0);
        begin
            int k = 0;
            while (bus.tmr_rdata != 32'd9 && k < 40) begin
                step();
                k++;
            end
        end
        chk("tmr_at9",      bus.tmr_rdata, 32'd9);
        chk("tmr_at9_mtip", mip[0],        1'b0);
        step();
        chk("tmr_at10",      bus.tmr_rdata, 32'd10);
        chk("tmr_at10_mtip", mip[0],        1'b1);
        tmr_wr(2'd2, 32'hFFFF_FFFF);
        chk("tmr_cmp_lo_mtip", mip[0], 1'b0);
        tmr_wr(2'd1, 32'hFFFF_FFFF);
        tmr_wr(2'd0, 32'hFFFF_FFFF);
        bus.tmr_sel = 2'd1;
        #1;
        chk("tmr_max_hi", bus.tmr_rdata, 32'hFFFF_FFFF);
        step();
        chk("tmr_wrap_hi", bus.tmr_rdata, 32'h0);
        bus.tmr_sel = 2'd0;
        #1;
        chk("tmr_wrap_lo", bus.tmr_rdata, 32'h0);
        tmr_wr(2'd0, 32'h1234);
        chk("tmr_wr_beats_inc", bus.tmr_rdata, 32'h1234);
        step();
`else
        tmr_wr(2'd0, 32'h5);
        chk("notmr_rdata", bus.tmr_rdata, 32'h0);
        irq_tmr = 1'b1;
        step();
        chk("notmr_mtip", mip[0], 1'b1);
        irq_tmr = 1'b0;
        step();
        chk("notmr_mtip_lvl", mip[0], 1'b0);
`endif
        repeat (3) step();
        run_cmp = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
